// File: rtl/bps_pkg.sv
// Shared constants for the bit-rate tick generator.
//   DIV_MIN     : smallest divisor accepted by a runtime load
//   MODE_*      : clk_bps output forms
//   DIV_*       : prescaler divisors for a 100 MHz clock with 16x oversampling
package bps_pkg;

   localparam int unsigned DIV_MIN = 2;

   typedef enum logic {
      MODE_PULSE  = 1'b0,
      MODE_SQUARE = 1'b1
   } mode_e;

   localparam int unsigned DIV_9600   = 651;
   localparam int unsigned DIV_19200  = 326;
   localparam int unsigned DIV_115200 = 54;

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up counter with synchronous clear.
//   clk     : rising-edge clock
//   rst_n   : asynchronous reset, active HIGH (historical name)
//   en      : count enable
//   clr     : synchronous clear, overrides en
//   modulus : count length N; one bit wider than cnt so N = 2^W is representable
//   cnt     : current count, 0..N-1
//   wrap    : combinational, high when the next enabled edge returns cnt to 0
module mod_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clr,
   input  logic [W:0]   modulus,
   output logic [W-1:0] cnt,
   output logic         wrap
);

   logic [W-1:0] cnt_d, cnt_q;
   logic [W:0]   last;
   logic [W:0]   cnt_ext;

   assign last    = modulus - (W+1)'(1);
   assign cnt_ext = {1'b0, cnt_q};

   // Only an exact match on the last count is a wrap event.
   assign wrap = en && (cnt_ext == last);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         // >= so an out-of-range count recovers on the next enabled edge.
         if (cnt_ext >= last) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/bps_tick_gen.sv
// Two-stage baud / tick generator.
// A prescaler divides the clock by a runtime-loadable divisor to give an
// oversample tick; a second counter divides that by OVS to give the bit-rate tick.
//   clk        : rising-edge clock
//   rst_n      : asynchronous reset, active HIGH (historical name)
//   en         : count enable
//   mode       : clk_bps form, 0 = pulse, 1 = square wave
//   div_val    : new prescaler divisor
//   div_load   : strobe, load div_val (rejected if below DIV_MIN)
//   sync_clear : strobe, restart the phase of both stages
//   tick_ovs   : one-cycle pulse every div_reg enabled cycles
//   tick_bps   : one-cycle pulse every div_reg*OVS enabled cycles
//   clk_bps    : bit-rate clock enable in the selected form
//   div_err    : sticky, set by a rejected divisor load
module bps_tick_gen
   import bps_pkg::*;
#(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned OVS         = 16,
   parameter int unsigned OVS_W       = 8,
   parameter int unsigned DIV_DEFAULT = 651
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             mode,
   input  logic [CNT_W-1:0] div_val,
   input  logic             div_load,
   input  logic             sync_clear,
   output logic             tick_ovs,
   output logic             tick_bps,
   output logic             clk_bps,
   output logic             div_err
);

   logic [CNT_W-1:0] div_reg_d, div_reg_q;
   logic             div_err_d, div_err_q;
   logic             tick_ovs_d, tick_ovs_q;
   logic             tick_bps_d, tick_bps_q;
   logic             clk_bps_d, clk_bps_q;

   logic             load_ok;
   logic             load_bad;
   logic             cnt_clr;
   logic             pre_wrap;
   logic             ovs_wrap;
   logic [CNT_W-1:0] pre_cnt;
   logic [OVS_W-1:0] ovs_cnt;

   assign load_ok  = div_load && (div_val >= CNT_W'(DIV_MIN));
   assign load_bad = div_load && !load_ok;
   // A rejected load still outranks sync_clear but leaves the counters running.
   assign cnt_clr  = load_ok || (sync_clear && !div_load);

   mod_counter #(
      .W (CNT_W)
   ) u_prescaler (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .clr     (cnt_clr),
      .modulus ({1'b0, div_reg_q}),
      .cnt     (pre_cnt),
      .wrap    (pre_wrap)
   );

   mod_counter #(
      .W (OVS_W)
   ) u_ovs_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (pre_wrap),
      .clr     (cnt_clr),
      .modulus ((OVS_W+1)'(OVS)),
      .cnt     (ovs_cnt),
      .wrap    (ovs_wrap)
   );

   // Counter values are kept only as observation points.
   logic unused_cnt;
   assign unused_cnt = ^{pre_cnt, ovs_cnt};

   always_comb begin
      div_reg_d  = div_reg_q;
      div_err_d  = div_err_q;
      tick_ovs_d = pre_wrap;
      // ovs_wrap already implies pre_wrap, so tick_bps only fires with tick_ovs.
      tick_bps_d = ovs_wrap;
      if (mode == MODE_SQUARE) begin
         clk_bps_d = clk_bps_q ^ ovs_wrap;
      end else begin
         clk_bps_d = ovs_wrap;
      end

      if (load_ok) begin
         div_reg_d = div_val;
         div_err_d = 1'b0;
      end else if (load_bad) begin
         div_err_d = 1'b1;
      end

      if (cnt_clr) begin
         tick_ovs_d = 1'b0;
         tick_bps_d = 1'b0;
         clk_bps_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         div_reg_q  <= CNT_W'(DIV_DEFAULT);
         div_err_q  <= 1'b0;
         tick_ovs_q <= 1'b0;
         tick_bps_q <= 1'b0;
         clk_bps_q  <= 1'b0;
      end else begin
         div_reg_q  <= div_reg_d;
         div_err_q  <= div_err_d;
         tick_ovs_q <= tick_ovs_d;
         tick_bps_q <= tick_bps_d;
         clk_bps_q  <= clk_bps_d;
      end
   end

   assign tick_ovs = tick_ovs_q;
   assign tick_bps = tick_bps_q;
   assign clk_bps  = clk_bps_q;
   assign div_err  = div_err_q;

endmodule
